// File: rtl/fc_pkg.sv
// Shared types and saturation helpers for the FC layer engine.
// Helpers work on sign-extended 64-bit values and clamp to a w-bit signed range.
package fc_pkg;

    typedef enum logic [1:0] {IDLE, MAC, FLUSH, DRAIN} fc_state_e;

    function automatic logic signed [63:0] sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

    function automatic logic signed [63:0] sat_mul(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int w);
        logic signed [63:0] p;
        p = a * b;
        if (p > sat_max(w)) return sat_max(w);
        if (p < sat_min(w)) return sat_min(w);
        return p;
    endfunction

    // Overflow: equal addend signs and a w-bit sum whose sign differs from them.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int w);
        logic signed [63:0] s;
        logic signed [63:0] s_w;
        s   = a + b;
        s_w = (s <<< (64 - w)) >>> (64 - w);
        if (((a < 0) == (b < 0)) && ((s_w < 0) != (a < 0)))
            return (a < 0) ? sat_min(w) : sat_max(w);
        return s;
    endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// One MAC lane: registered saturated product, then saturating accumulate (2-cycle pipe).
// acc_d_o exposes the next accumulator value so results can be latched on the final add.
module fc_mac_lane
    import fc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clr_i,
    input  logic                    en_i,
    input  logic signed [WIDTH-1:0] x_i,
    input  logic signed [WIDTH-1:0] w_i,
    output logic signed [WIDTH-1:0] acc_d_o
);

    logic signed [WIDTH-1:0] prod_q, prod_d;
    logic signed [WIDTH-1:0] acc_q, acc_d;
    logic                    prod_vld_q;
    logic signed [63:0]      x_ext, w_ext, p_ext, acc_ext;

    always_comb begin
        x_ext   = {{(64-WIDTH){x_i[WIDTH-1]}}, x_i};
        w_ext   = {{(64-WIDTH){w_i[WIDTH-1]}}, w_i};
        p_ext   = {{(64-WIDTH){prod_q[WIDTH-1]}}, prod_q};
        acc_ext = {{(64-WIDTH){acc_q[WIDTH-1]}}, acc_q};
        prod_d  = WIDTH'(sat_mul(x_ext, w_ext, WIDTH));
        acc_d   = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (prod_vld_q) begin
            acc_d = WIDTH'(sat_add(acc_ext, p_ext, WIDTH));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
            acc_q      <= '0;
        end else begin
            prod_vld_q <= en_i;
            if (en_i) begin
                prod_q <= prod_d;
            end
            acc_q <= acc_d;
        end
    end

    assign acc_d_o = acc_d;

endmodule

// File: rtl/fc_mem.sv
// Simple dual-port x storage: synchronous write, registered read (1-cycle latency).
// No backpressure; array is not reset since readers track validity separately.
module fc_mem #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 8,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/fc_layer_par.sv
// P-lane fully-connected layer with double-buffered x and external registered weight ROM.
// N+2 cycles from MAC entry to first output; input stalls only while both x banks are full.
module fc_layer_par
    import fc_pkg::*;
#(
    parameter  int M     = 10,
    parameter  int N     = 8,
    parameter  int WIDTH = 16,
    parameter  int P     = 2,
    parameter  int RELU  = 1,
    localparam int AW    = $clog2((M / P) * N)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    input_valid,
    output logic                    input_ready,
    input  logic signed [WIDTH-1:0] input_data,
    output logic                    output_valid,
    input  logic                    output_ready,
    output logic signed [WIDTH-1:0] output_data,
    output logic [AW-1:0]           w_addr,
    input  logic [P*WIDTH-1:0]      w_data
);

    localparam int G  = M / P;
    localparam int GW = (G > 1) ? $clog2(G) : 1;
    localparam int NW = $clog2(N);
    localparam int LW = (P > 1) ? $clog2(P) : 1;
    localparam logic [NW-1:0] N_LAST = NW'(N - 1);
    localparam logic [GW-1:0] G_LAST = GW'(G - 1);
    localparam logic [LW-1:0] L_LAST = LW'(P - 1);

    fc_state_e               state_q;
    logic [GW-1:0]           g_q;
    logic [NW-1:0]           n_q;
    logic [LW-1:0]           lane_q;
    logic [AW-1:0]           w_addr_q;
    logic                    out_vld_q;
    logic                    mac_vld_q;
    logic                    rd_sel_q;
    logic signed [WIDTH-1:0] res_q [P];

    logic [1:0]              full_q, full_d;
    logic                    wr_sel_q;
    logic [NW-1:0]           wr_cnt_q;

    logic                    in_fire, in_last, out_fire, grp_done, vec_done;
    logic [WIDTH-1:0]        xr0, xr1;
    logic signed [WIDTH-1:0] x_rd;
    logic signed [WIDTH-1:0] acc_nxt  [P];
    logic signed [WIDTH-1:0] relu_res [P];

    assign input_ready  = !full_q[wr_sel_q];
    assign in_fire      = input_valid && input_ready;
    assign in_last      = in_fire && (wr_cnt_q == N_LAST);
    assign out_fire     = out_vld_q && output_ready;
    assign grp_done     = (state_q == DRAIN) && out_fire && (lane_q == L_LAST);
    assign vec_done     = grp_done && (g_q == G_LAST);

    assign output_valid = out_vld_q;
    assign output_data  = res_q[lane_q];
    assign w_addr       = w_addr_q;

    // Set and clear always hit different banks, so both apply in one cycle.
    always_comb begin
        full_d = full_q;
        if (in_last) begin
            full_d[wr_sel_q] = 1'b1;
        end
        if (vec_done) begin
            full_d[rd_sel_q] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q   <= '0;
            wr_sel_q <= 1'b0;
            wr_cnt_q <= '0;
        end else begin
            full_q <= full_d;
            if (in_fire) begin
                if (in_last) begin
                    wr_cnt_q <= '0;
                    wr_sel_q <= ~wr_sel_q;
                end else begin
                    wr_cnt_q <= wr_cnt_q + NW'(1);
                end
            end
        end
    end

    fc_mem #(.WIDTH(WIDTH), .DEPTH(N)) u_xbank0 (
        .clk     (clk),
        .we_i    (in_fire && !wr_sel_q),
        .waddr_i (wr_cnt_q),
        .wdata_i (input_data),
        .raddr_i (n_q),
        .rdata_o (xr0)
    );

    fc_mem #(.WIDTH(WIDTH), .DEPTH(N)) u_xbank1 (
        .clk     (clk),
        .we_i    (in_fire && wr_sel_q),
        .waddr_i (wr_cnt_q),
        .wdata_i (input_data),
        .raddr_i (n_q),
        .rdata_o (xr1)
    );

    assign x_rd = rd_sel_q ? xr1 : xr0;

    for (genvar p = 0; p < P; p++) begin : g_lane
        fc_mac_lane #(.WIDTH(WIDTH)) u_lane (
            .clk     (clk),
            .reset   (reset),
            .clr_i   ((state_q == MAC) && (n_q == '0)),
            .en_i    (mac_vld_q),
            .x_i     (x_rd),
            .w_i     (w_data[p*WIDTH +: WIDTH]),
            .acc_d_o (acc_nxt[p])
        );
    end

    always_comb begin
        for (int p = 0; p < P; p++) begin
            relu_res[p] = acc_nxt[p];
            if ((RELU != 0) && acc_nxt[p][WIDTH-1]) begin
                relu_res[p] = '0;
            end
        end
    end

    // The final accumulate lands on the last FLUSH edge, so results are latched from acc_nxt.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            g_q       <= '0;
            n_q       <= '0;
            lane_q    <= '0;
            w_addr_q  <= '0;
            out_vld_q <= 1'b0;
            mac_vld_q <= 1'b0;
            rd_sel_q  <= 1'b0;
            for (int p = 0; p < P; p++) begin
                res_q[p] <= '0;
            end
        end else begin
            mac_vld_q <= (state_q == MAC);
            case (state_q)
                IDLE: begin
                    if (full_q[rd_sel_q]) begin
                        g_q      <= '0;
                        n_q      <= '0;
                        w_addr_q <= '0;
                        state_q  <= MAC;
                    end
                end
                MAC: begin
                    w_addr_q <= w_addr_q + AW'(1);
                    if (n_q == N_LAST) begin
                        n_q     <= '0;
                        state_q <= FLUSH;
                    end else begin
                        n_q <= n_q + NW'(1);
                    end
                end
                FLUSH: begin
                    if (n_q == NW'(1)) begin
                        n_q       <= '0;
                        lane_q    <= '0;
                        out_vld_q <= 1'b1;
                        state_q   <= DRAIN;
                        for (int p = 0; p < P; p++) begin
                            res_q[p] <= relu_res[p];
                        end
                    end else begin
                        n_q <= n_q + NW'(1);
                    end
                end
                DRAIN: begin
                    if (out_fire) begin
                        if (lane_q == L_LAST) begin
                            lane_q    <= '0;
                            out_vld_q <= 1'b0;
                            if (g_q == G_LAST) begin
                                rd_sel_q <= ~rd_sel_q;
                                w_addr_q <= '0;
                                state_q  <= IDLE;
                            end else begin
                                g_q     <= g_q + GW'(1);
                                state_q <= MAC;
                            end
                        end else begin
                            lane_q <= lane_q + LW'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_layer_par.sv
// Scoreboard bench: two DUTs (RELU=0 / RELU=1) in lockstep, checked against a saturating dot-product model.
module tb_fc_layer_par;

    localparam int M     = 4;
    localparam int N     = 3;
    localparam int WIDTH = 16;
    localparam int P     = 2;
    localparam int G     = M / P;
    localparam int AW    = $clog2(G * N);
    localparam longint MAXV = (64'sd1 <<< (WIDTH - 1)) - 1;
    localparam longint MINV = -(64'sd1 <<< (WIDTH - 1));

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    input_valid;
    logic signed [WIDTH-1:0] input_data;
    logic                    output_ready = 1'b1;
    logic                    rdy0, rdy1, ov0, ov1;
    logic signed [WIDTH-1:0] od0, od1;
    logic [AW-1:0]           wa0, wa1;
    logic [P*WIDTH-1:0]      wd0, wd1;

    int W [M][N];
    int q [2][$];
    int tests = 0;
    int errs  = 0;
    int acc_cnt = 0;
    int rmode = 0;
    int hold_at = -1;
    bit hold_v [2];
    logic signed [WIDTH-1:0] hold_d [2];
    int stalls [$];

    always #5 clk = ~clk;

    fc_layer_par #(.M(M), .N(N), .WIDTH(WIDTH), .P(P), .RELU(0)) u0 (
        .clk(clk), .reset(reset), .input_valid(input_valid), .input_ready(rdy0),
        .input_data(input_data), .output_valid(ov0), .output_ready(output_ready),
        .output_data(od0), .w_addr(wa0), .w_data(wd0)
    );

    fc_layer_par #(.M(M), .N(N), .WIDTH(WIDTH), .P(P), .RELU(1)) u1 (
        .clk(clk), .reset(reset), .input_valid(input_valid), .input_ready(rdy1),
        .input_data(input_data), .output_valid(ov1), .output_ready(output_ready),
        .output_data(od1), .w_addr(wa1), .w_data(wd1)
    );

    function automatic logic [P*WIDTH-1:0] rom_word(input logic [AW-1:0] a);
        logic [P*WIDTH-1:0] r;
        int ai;
        r  = '0;
        ai = int'(a);
        if (ai < G * N) begin
            for (int p = 0; p < P; p++) begin
                r[p*WIDTH +: WIDTH] = WIDTH'(W[(ai / N) * P + p][ai % N]);
            end
        end
        return r;
    endfunction

    always @(posedge clk) begin
        wd0 <= rom_word(wa0);
        wd1 <= rom_word(wa1);
    end

    function automatic longint clampw(input longint v);
        if (v > MAXV) return MAXV;
        if (v < MINV) return MINV;
        return v;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic push_exp(input int xs[$]);
        longint acc;
        for (int m = 0; m < M; m++) begin
            acc = 0;
            for (int n = 0; n < N; n++) begin
                acc = clampw(acc + clampw(longint'(xs[n]) * longint'(W[m][n])));
            end
            q[0].push_back(int'(acc));
            q[1].push_back(acc < 0 ? 0 : int'(acc));
        end
    endtask

    task automatic mon(input int k, input logic v, input logic signed [WIDTH-1:0] d);
        int e;
        if (hold_v[k]) begin
            tests++;
            if (!v || d !== hold_d[k]) begin
                errs++;
                $display("FAIL stall_hold dut%0d: valid=%0b data=%0d expected valid=1 data=%0d",
                         k, v, d, hold_d[k]);
            end
        end
        if (v && output_ready) begin
            tests++;
            if (q[k].size() == 0) begin
                errs++;
                $display("FAIL extra_output dut%0d: data=%0d with no expected value", k, d);
            end else begin
                e = q[k].pop_front();
                if (int'(d) !== e) begin
                    errs++;
                    $display("FAIL output dut%0d: got %0d expected %0d", k, d, e);
                end
            end
            if (k == 0) acc_cnt++;
        end
        hold_v[k] = v && !output_ready;
        hold_d[k] = d;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            hold_v[0] = 1'b0;
            hold_v[1] = 1'b0;
        end else begin
            mon(0, ov0, od0);
            mon(1, ov1, od1);
        end
    end

    // output_ready pattern generator: 0 = always ready, 1 = toggle (+ one 10-cycle hold), 2 = random.
    always @(posedge clk) begin : rdy_drv
        static bit tog = 1'b0;
        static int hold_left = 0;
        static int done_at = -1;
        #1;
        case (rmode)
            1: begin
                if (hold_at >= 0 && done_at != hold_at && acc_cnt == hold_at && ov0) begin
                    hold_left = 10;
                    done_at   = hold_at;
                end
                if (hold_left > 0) begin
                    output_ready = 1'b0;
                    hold_left--;
                end else begin
                    output_ready = tog;
                end
                tog = ~tog;
            end
            2:       output_ready = ($urandom_range(0, 3) != 0);
            default: output_ready = 1'b1;
        endcase
    end

    task automatic send_words(input int xs[$], input bit gaps);
        int st;
        bit f;
        stalls.delete();
        foreach (xs[i]) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                input_valid = 1'b0;
                @(posedge clk); #1;
            end
            input_valid = 1'b1;
            input_data  = WIDTH'(xs[i]);
            st = 0;
            forever begin
                @(negedge clk);
                f = rdy0 && rdy1;
                @(posedge clk); #1;
                if (f) break;
                st++;
                if (st > 400) begin
                    tests++; errs++;
                    $display("FAIL input_timeout: word %0d stalled %0d cycles, limit 400", i, st);
                    input_valid = 1'b0;
                    return;
                end
            end
            stalls.push_back(st);
        end
        input_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((q[0].size() != 0 || q[1].size() != 0) && t < 3000) begin
            @(posedge clk); t++;
        end
        if (t >= 3000) begin
            tests++; errs++;
            $display("FAIL drain_timeout: %0d/%0d results pending, required 0", q[0].size(), q[1].size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    function automatic int rnd(input int lim);
        return int'($urandom_range(0, 2 * lim)) - lim;
    endfunction

    task automatic rand_w(input int lim);
        for (int m = 0; m < M; m++)
            for (int n = 0; n < N; n++)
                W[m][n] = rnd(lim);
    endtask

    task automatic rand_vec(input int lim, output int xs[$]);
        xs.delete();
        for (int n = 0; n < N; n++) xs.push_back(rnd(lim));
    endtask

    initial begin : main
        int xs[$];
        int all[$];
        int base, t, low_first, exp_low;

        reset = 1'b1;
        input_valid = 1'b0;
        input_data = '0;
        for (int m = 0; m < M; m++) for (int n = 0; n < N; n++) W[m][n] = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_input_ready0", rdy0, 1);
        chk("rst_input_ready1", rdy1, 1);
        chk("rst_output_valid0", ov0, 0);
        chk("rst_output_valid1", ov1, 0);
        chk("rst_output_data0", od0, 0);
        chk("rst_output_data1", od1, 0);
        chk("rst_w_addr0", wa0, 0);
        chk("rst_w_addr1", wa1, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Basic dot products, with and without ReLU.
        W = '{'{1, 2, 3}, '{0, 1, 0}, '{-1, 0, 0}, '{2, 2, 2}};
        xs = '{1, 2, 3};
        push_exp(xs);
        send_words(xs, 0);
        wait_idle();

        // Product saturation, positive and negative accumulator saturation.
        W = '{'{200, 0, 0}, '{0, 1, 1}, '{0, -1, -1}, '{7, -3, 1}};
        xs = '{300, 20000, 20000};
        push_exp(xs);
        send_words(xs, 0);
        wait_idle();

        // Three vectors streamed back-to-back with input_valid held high.
        rand_w(100);
        all.delete();
        for (int v = 0; v < 3; v++) begin
            rand_vec(100, xs);
            push_exp(xs);
            foreach (xs[i]) all.push_back(xs[i]);
        end
        send_words(all, 0);
        low_first = 0;
        for (int i = 0; i < 2 * N && i < stalls.size(); i++) low_first += stalls[i];
        chk("dbuf_first_2N_stalls", low_first, 0);
        exp_low = (N + 1) + G * (N + 2 + P) - 2 * N;
        chk("dbuf_third_vec_stall", (stalls.size() > 2 * N) ? stalls[2 * N] : -1, exp_low);
        wait_idle();

        // Toggling output_ready plus a 10-cycle hold in the middle of a drain.
        rand_w(300);
        hold_at = acc_cnt + 1;
        rmode = 1;
        for (int v = 0; v < 2; v++) begin
            rand_vec(300, xs);
            push_exp(xs);
            send_words(xs, 0);
        end
        wait_idle();

        // Full-range random data, random gaps and random backpressure.
        rand_w(32767);
        rmode = 2;
        for (int v = 0; v < 6; v++) begin
            rand_vec(32767, xs);
            push_exp(xs);
            send_words(xs, 1);
        end
        wait_idle();
        rmode = 0;
        repeat (2) @(posedge clk); #1;

        // Reset while group 1 is in MAC, with a partial next vector already loaded.
        rand_w(50);
        base = acc_cnt;
        rand_vec(50, xs);
        push_exp(xs);
        send_words(xs, 0);
        t = 0;
        while (acc_cnt < base + P && t < 500) begin
            @(negedge clk); t++;
        end
        chk("rst_mid_reach_group1", (acc_cnt >= base + P) ? 1 : 0, 1);
        @(posedge clk); #1;
        input_valid = 1'b1;
        input_data  = WIDTH'(rnd(50));
        @(posedge clk); #1;
        input_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        q[0].delete();
        q[1].delete();
        @(negedge clk);
        chk("rst_mid_output_valid", ov0, 0);
        chk("rst_mid_input_ready", rdy0, 1);
        chk("rst_mid_w_addr", wa0, 0);
        @(posedge clk); #1;
        rand_vec(50, xs);
        push_exp(xs);
        send_words(xs, 0);
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fc_layer_par.md
Name: fc_layer_par

Overview:
- Parametrised fully-connected layer engine: y[m] = act(sum over n of W[m][n]*x[n]), for m = 0..M-1 and n = 0..N-1.
- Generalises the single-lane FC blocks in several ways:
  - P parallel MAC lanes.
  - Weights fetched from an external weight-ROM port instead of a hard-wired instance.
  - Optional ReLU.
  - Double-buffered x storage, so vector k+1 streams in while vector k is computed and drained.
- Sits between streaming layers; input and output use a valid/ready handshake.

Parameters:
- M, 10, number of output rows; M % P == 0 is required.
- N, 8, input vector length, N >= 2.
- WIDTH, 16, signed data and weight width.
- P, 2, parallel MAC lanes (rows per group).
- RELU, 1, 1 = clamp results <= 0 to 0; 0 = pass results through unchanged.

Ports:
- clk, in, 1, clock; all logic is on the rising edge.
- reset, in, 1, synchronous active-high reset.
- input_valid, in, 1, input_data is valid.
- input_ready, out, 1, block accepts input_data this cycle.
- input_data, in, WIDTH, signed x element; elements arrive in order n = 0..N-1.
- output_valid, out, 1, output_data is valid.
- output_ready, in, 1, downstream accepts output_data.
- output_data, out, WIDTH, signed y element; elements leave in order m = 0..M-1.
- w_addr, out, clog2((M/P)*N), weight ROM address g*N+n.
- w_data, in, P*WIDTH, lane p slice is W[g*P+p][n]; valid one cycle after w_addr (registered ROM).

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - input_ready = 1, output_valid = 0, output_data = 0, w_addr = 0.
  - Both x banks empty; wr_sel = rd_sel = 0; compute FSM in IDLE.
- Reset mid-operation discards any partial vector, accumulators and pending outputs.
- Loader (x double buffer):
  - input_ready = !full[wr_sel].
  - A transfer (input_valid & input_ready) writes bank[wr_sel][wr_cnt].
  - On the N-th transfer: set full[wr_sel], toggle wr_sel, clear wr_cnt.
  - A third vector is stalled (input_ready = 0) while both banks are full.
- Compute FSM: IDLE -> MAC -> FLUSH -> DRAIN -> (MAC for next group | IDLE).
  - IDLE: wait for full[rd_sel]; then g = 0 and go to MAC.
  - MAC, N cycles: issue w_addr = g*N+n and x read address n, for n = 0..N-1. The x bank read is also registered, so x and w arrive aligned.
  - Per-lane pipeline:
    - Stage 1: product = x*w at 2*WIDTH, saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1], then registered.
    - Stage 2: saturating add into the accumulator, which was cleared at group start.
  - FLUSH: 2 cycles while the pipeline empties; then apply ReLU if RELU = 1 and latch the P results into the output register file.
  - DRAIN:
    - Present lanes p = 0..P-1 in order; output_valid = 1.
    - output_data stays stable while output_valid & !output_ready.
    - Advance one lane per cycle while output_ready = 1; back-to-back output is allowed.
  - After lane P-1 is accepted:
    - If g < M/P-1: g++ and go to MAC.
    - Else: clear full[rd_sel], toggle rd_sel, go to IDLE. If the other bank is already full, IDLE exits on the next cycle.
- Timing:
  - Group compute latency: N+2 cycles from MAC entry to the first output_valid.
  - Full vector, no backpressure: (M/P)*(N+2+P) cycles.
- Simultaneous set/clear of full[] events always target different banks; both must take effect in the same cycle.
- Saturation arithmetic is identical to the existing FC data path:
  - Overflow is detected when both addend signs are equal and the sum sign differs.
  - Positive overflow clamps to the maximum value; negative overflow clamps to the minimum.

Decomposition:
- Package fc_pkg holds:
  - The FSM state enum (IDLE, MAC, FLUSH, DRAIN).
  - Saturation helper functions sat_mul and sat_add, parametrised on WIDTH.
- Sub-module fc_mac_lane: product register plus saturating accumulator with clear and enable. fc_layer_par instantiates it P times via generate.
- The x double buffer stays inline: two instances of the existing memory module.

Test Plan:
- Basic case (M=4, N=3, P=2, WIDTH=16, RELU=0): W rows {1,2,3}, {0,1,0}, {-1,0,0}, {2,2,2}; x = {1,2,3} -> outputs 14, 2, -1, 12 in order.
- RELU=1 with the same data: outputs 14, 2, 0, 12.
- Saturation:
  - x[0] = 300 with w = 200 (all other terms 0): product clamps -> output 32767.
  - Terms 20000 + 20000: accumulator clamps -> 32767.
  - Terms -20000 + -20000: accumulator clamps -> -32768.
- Double buffering: stream three vectors back-to-back with input_valid held at 1.
  - input_ready stays 1 for the first 2N words, then drops until vector 0's last output is accepted.
  - All 3*M results are correct and in order.
- Backpressure: output_ready toggled 1/0 every cycle, plus a 10-cycle low hold mid-DRAIN -> output_data stays stable while stalled; no output is lost or duplicated.
- Reset mid-MAC of group 1 -> next cycle output_valid = 0 and input_ready = 1; a fresh vector afterwards yields correct results.
